// File: rtl/spi_lfsr_master.sv
// spi_lfsr_master: SPI mode-0 master, one byte per transaction MSB first, received byte on valid/ready
module spi_lfsr_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);
  localparam int GW = $clog2(CS_GAP + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [7:0] div_q, div_d, tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [2:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic done, div_end;
  assign div_end = div_q == 8'(CLK_DIV - 1);
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    tx_d = tx_q;
    rx_sh_d = rx_sh_q;
    bit_d = bit_q;
    gap_d = gap_q;
    cs_d = cs_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        tx_d = tx_data;
        mosi_d = tx_data[7];
        cs_d = 1'b0;
        div_d = '0;
        bit_d = '0;
      end
      SETUP: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        state_d = div_end ? SHIFT : SETUP;
      end
      SHIFT: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end && !sclk_q) begin
          sclk_d = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
        end
        if (div_end && sclk_q) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd7) state_d = HOLD;
          else begin
            bit_d = bit_q + 3'd1;
            tx_d = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end
        end
      end
      HOLD: begin
        div_d = div_end ? 8'd0 : div_q + 8'd1;
        if (div_end) begin
          state_d = GAP;
          cs_d = 1'b1;
          gap_d = '0;
          done = 1'b1;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        state_d = (gap_q == GW'(CS_GAP - 1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    rx_data_d = done ? rx_sh_q : rx_data_q;
    rx_valid_d = done | (rx_valid_q & ~rx_ready);
    overrun_d = overrun_q | (done & rx_valid_q & ~rx_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      tx_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      cs_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      tx_q <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      cs_q <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      rx_valid_q <= rx_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign busy = state_q != IDLE;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun = overrun_q;
  assign cs = cs_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
endmodule

// File: tb/tb_spi_lfsr_master.sv
// tb_spi_lfsr_master: directed checks of the SPI master in loopback and against a mode-0 slave model
module tb_spi_lfsr_master;
  logic clk, rst_n, start, rx_ready, miso, sel_loop;
  logic [7:0] tx_data, rx_data, slave_byte;
  logic busy, rx_valid, overrun, cs, sclk, mosi, miso_slv;
  logic start1, busy1, rx_valid1, overrun1, cs1, sclk1, mosi1;
  logic [7:0] tx1, rx_data1;
  int cyc = 0, rises = 0, cs_low = 0, rises1 = 0, cs_low1 = 0, fcnt = 0, fbase = 0, idx;
  int checks = 0, errors = 0;
  int t_rise, t_idle, t_fall, rv_rise, r0, c0, f1, r1;

  spi_lfsr_master #(.CLK_DIV(4), .CS_GAP(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso));

  spi_lfsr_master #(.CLK_DIV(1), .CS_GAP(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1), .busy(busy1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(1'b1), .overrun(overrun1),
    .cs(cs1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (!cs) cs_low++;
  always @(posedge clk) if (!cs1) cs_low1++;
  always @(posedge sclk) rises++;
  always @(posedge sclk1) rises1++;
  // mode-0 slave: bit index = sclk falls since cs fell
  always @(negedge sclk) fcnt++;
  always @(negedge cs) fbase = fcnt;
  assign idx = fcnt - fbase;
  assign miso_slv = (idx >= 0 && idx < 8) ? slave_byte[3'(7 - idx)] : 1'b0;
  assign miso = sel_loop ? mosi : miso_slv;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [7:0] b, input bit hammer);
    bit ok, prev_cs;
    tx_data = b;
    start = 1;
    step(1);
    t_fall = cyc;
    start = hammer;
    ok = 0;
    prev_cs = cs;
    rv_rise = -1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (hammer) tx_data = 8'($urandom);
      step(1);
      if (cs && !prev_cs) begin
        t_rise = cyc;
        rv_rise = int'(rx_valid);
      end
      prev_cs = cs;
      if (!busy) begin
        ok = 1;
        t_idle = cyc;
        start = 0;
      end
    end
    chk("txn_timeout", 32'(ok), 1);
  endtask

  initial begin
    rst_n = 0; start = 0; start1 = 0; tx_data = 0; tx1 = 0; rx_ready = 1; sel_loop = 1; slave_byte = 0;
    step(2);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_fast_cs", cs1, 1);
    rst_n = 1;
    step(2);

    r0 = rises; c0 = cs_low;
    run_txn(8'hA5, 0);
    chk("lb_cs_low", cs_low - c0, 72);
    chk("lb_rises", rises - r0, 8);
    chk("lb_rx_data", rx_data, 8'hA5);
    chk("lb_valid_at_cs_rise", rv_rise, 1);
    chk("lb_gap", t_idle - t_rise, 2);

    sel_loop = 0;
    slave_byte = 8'h3C;
    run_txn(8'h00, 0);
    chk("sl_rx0", rx_data, 8'h3C);
    f1 = t_fall; r1 = t_rise;
    slave_byte = 8'h78;
    run_txn(8'hFF, 0);
    chk("sl_rx1", rx_data, 8'h78);
    chk("sl_overrun", overrun, 0);
    chk("sl_cs_high_gap", 32'(t_fall - r1 >= 2), 1);
    chk("sl_period", t_fall - f1, 75);

    sel_loop = 1;
    r0 = rises; c0 = cs_low;
    run_txn(8'h96, 1);
    step(5);
    chk("hm_rx_data", rx_data, 8'h96);
    chk("hm_rises", rises - r0, 8);
    chk("hm_cs_low", cs_low - c0, 72);
    chk("hm_idle", busy, 0);

    rx_ready = 0;
    run_txn(8'h11, 0);
    chk("ov_valid0", rx_valid, 1);
    chk("ov_overrun0", overrun, 0);
    run_txn(8'h22, 0);
    chk("ov_rx_data", rx_data, 8'h22);
    chk("ov_valid1", rx_valid, 1);
    chk("ov_overrun1", overrun, 1);
    rx_ready = 1;
    step(1);
    chk("ov_consumed", rx_valid, 0);
    chk("ov_sticky", overrun, 1);

    r0 = rises;
    tx_data = 8'hF0;
    start = 1;
    step(1);
    start = 0;
    for (int i = 0; i < 500 && rises - r0 < 3; i++) step(1);
    chk("ab_rises", rises - r0, 3);
    rst_n = 0;
    #2;
    chk("ab_cs", cs, 1);
    chk("ab_sclk", sclk, 0);
    chk("ab_busy", busy, 0);
    chk("ab_valid", rx_valid, 0);
    chk("ab_overrun", overrun, 0);
    step(1);
    rst_n = 1;
    step(1);
    r0 = rises;
    run_txn(8'hC3, 0);
    chk("ab_rx_data", rx_data, 8'hC3);
    chk("ab_rises_after", rises - r0, 8);

    r0 = rises1; c0 = cs_low1;
    tx1 = 8'h5A;
    start1 = 1;
    step(1);
    start1 = 0;
    for (int i = 0; i < 200 && busy1; i++) step(1);
    chk("fast_done", busy1, 0);
    chk("fast_cs_low", cs_low1 - c0, 18);
    chk("fast_rises", rises1 - r0, 8);
    chk("fast_rx_data", rx_data1, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
